// File: rtl/dma_stream_responder.sv
// Purpose : word-memory DMA responder serving NUM_RD read streams and NUM_WR write streams
//           with a programmable beat period, sliding-window address replay and write capture.
// Latency : read data is registered: ob_we/ob_data appear 1 cycle after the launch phase.
// Backpr. : none. Ports pace themselves through their phase counters; enable low or a dropped
//           request level freezes a port's phase, and nothing is launched while it is frozen.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   enable            global run; low freezes every port
//   mem_we/addr/wdata backdoor memory write (lowest write priority)
//   cfg_load          per-port config strobe, read ports in [NUM_RD-1:0], write ports above
//   cfg_base/len/step window start, beats per window (0 = DEPTH), advance at window end
//   reads_en, ob_we, ob_data         read request level, data strobe, data per read port
//   writes_en, ib_re, ib_data, ib_valid  write request level, pop strobe, engine result
//   wr_count          captured words per write port, saturating
module dma_stream_responder #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_RD     = 4,
  parameter int NUM_WR     = 2,
  parameter int PERIOD     = 3,
  parameter int BEAT_PHASE = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           mem_we,
  input  logic [ADDR_WIDTH-1:0]          mem_addr,
  input  logic [DATA_WIDTH-1:0]          mem_wdata,
  input  logic [NUM_RD+NUM_WR-1:0]       cfg_load,
  input  logic [ADDR_WIDTH-1:0]          cfg_base,
  input  logic [ADDR_WIDTH-1:0]          cfg_len,
  input  logic [ADDR_WIDTH-1:0]          cfg_step,
  input  logic [NUM_RD-1:0]              reads_en,
  output logic [NUM_RD-1:0]              ob_we,
  output logic [NUM_RD*DATA_WIDTH-1:0]   ob_data,
  input  logic [NUM_WR-1:0]              writes_en,
  output logic [NUM_WR-1:0]              ib_re,
  input  logic [NUM_WR*DATA_WIDTH-1:0]   ib_data,
  input  logic [NUM_WR-1:0]              ib_valid,
  output logic [NUM_WR*16-1:0]           wr_count
);

  localparam int NP    = NUM_RD + NUM_WR;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = 4;

  localparam logic [PW-1:0]         PH_LAST = PW'(PERIOD - 1);
  localparam logic [PW-1:0]         PH_BEAT = PW'(BEAT_PHASE);
  localparam logic [PW-1:0]         PH_ONE  = PW'(1);
  localparam logic [ADDR_WIDTH-1:0] A_ONE   = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Per-port state; index k < NUM_RD is a read port, k >= NUM_RD is write port k-NUM_RD.
  logic [PW-1:0]         phase [NP];
  logic [ADDR_WIDTH-1:0] ws    [NP];
  logic [ADDR_WIDTH-1:0] ptr   [NP];
  logic [ADDR_WIDTH-1:0] cnt   [NP];
  logic [ADDR_WIDTH-1:0] len   [NP];
  logic [ADDR_WIDTH-1:0] step  [NP];

  logic [NP-1:0]         req;
  logic [NP-1:0]         launch;
  logic [NP-1:0]         adv;
  logic [NUM_WR-1:0]     wcap;
  logic                  wrap  [NP];
  logic [ADDR_WIDTH-1:0] ws_nx [NP];

  assign req = {writes_en, reads_en};

  // A launch needs the port running and sitting on the beat phase; a cfg_load
  // in the same cycle wins and the beat is dropped.
  always_comb begin
    launch = '0;
    for (int k = 0; k < NP; k++) begin
      launch[k] = enable && req[k] && (phase[k] == PH_BEAT) && !cfg_load[k];
    end
  end

  // Write capture happens in the cycle ib_re is out, so it uses the registered strobe.
  always_comb begin
    wcap = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      wcap[j] = !rst && ib_re[j] && ib_valid[j] && !cfg_load[NUM_RD+j];
    end
  end

  // Read ports advance their pointer at launch, write ports at capture.
  assign adv = {wcap, launch[NUM_RD-1:0]};

  // len == 0 makes len-1 wrap to DEPTH-1, which is exactly a DEPTH-beat window.
  always_comb begin
    for (int k = 0; k < NP; k++) begin
      wrap[k]  = (cnt[k] == (len[k] - A_ONE));
      ws_nx[k] = ws[k] + step[k];
    end
  end

  // Port state. Reset also returns len/step to 0, so an unloaded port walks
  // the whole memory circularly from address 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NP; k++) begin
        phase[k] <= '0;
        ws[k]    <= '0;
        ptr[k]   <= '0;
        cnt[k]   <= '0;
        len[k]   <= '0;
        step[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NP; k++) begin
        if (cfg_load[k]) begin
          ws[k]    <= cfg_base;
          ptr[k]   <= cfg_base;
          cnt[k]   <= '0;
          phase[k] <= '0;
          len[k]   <= cfg_len;
          step[k]  <= cfg_step;
        end else begin
          if (enable && req[k]) begin
            phase[k] <= (phase[k] == PH_LAST) ? '0 : phase[k] + PH_ONE;
          end
          if (adv[k]) begin
            if (wrap[k]) begin
              ws[k]  <= ws_nx[k];
              ptr[k] <= ws_nx[k];
              cnt[k] <= '0;
            end else begin
              ptr[k] <= ptr[k] + A_ONE;
              cnt[k] <= cnt[k] + A_ONE;
            end
          end
        end
      end
    end
  end

  // Registered strobes and data. ob_data holds between beats; reads see the
  // memory contents from before any write landing in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ob_we    <= '0;
      ob_data  <= '0;
      ib_re    <= '0;
      wr_count <= '0;
    end else begin
      ob_we <= launch[NUM_RD-1:0];
      for (int i = 0; i < NUM_RD; i++) begin
        if (launch[i]) begin
          ob_data[i*DATA_WIDTH +: DATA_WIDTH] <= mem[ptr[i]];
        end
      end
      ib_re <= launch[NP-1:NUM_RD];
      for (int j = 0; j < NUM_WR; j++) begin
        if (cfg_load[NUM_RD+j]) begin
          wr_count[j*16 +: 16] <= '0;
        end else if (wcap[j] && (wr_count[j*16 +: 16] != 16'hFFFF)) begin
          wr_count[j*16 +: 16] <= wr_count[j*16 +: 16] + 16'd1;
        end
      end
    end
  end

  // Memory is never reset. Later assignments win, so the order gives the
  // priority: backdoor lowest, then write ports in ascending index.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    for (int j = 0; j < NUM_WR; j++) begin
      if (wcap[j]) begin
        mem[ptr[NUM_RD+j]] <= ib_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_dma_stream_responder.sv
// Purpose : bench for dma_stream_responder; two instances (PERIOD 3/phase 1 and PERIOD 1/phase 0)
//           share all inputs and are compared every cycle against a window-arithmetic model.
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpr. : none; directed scenarios followed by random traffic.
module tb_dma_stream_responder;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int NR = 4;
  localparam int NW = 2;
  localparam int NP = NR + NW;
  localparam int DEPTH = 1 << AW;
  localparam int P0 = 3;
  localparam int BP0 = 1;
  localparam int P1 = 1;
  localparam int BP1 = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, enable, mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [NP-1:0]     cfg_load;
  logic [AW-1:0]     cfg_base, cfg_len, cfg_step;
  logic [NR-1:0]     reads_en;
  logic [NW-1:0]     writes_en, ib_valid;
  logic [NW*DW-1:0]  ib_data;

  logic [NR-1:0]     ob_we_a, ob_we_b;
  logic [NR*DW-1:0]  ob_data_a, ob_data_b;
  logic [NW-1:0]     ib_re_a, ib_re_b;
  logic [NW*16-1:0]  wr_count_a, wr_count_b;

  dma_stream_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .NUM_WR(NW),
                         .PERIOD(P0), .BEAT_PHASE(BP0)) u_dut_a (
    .clk(clk), .rst(rst), .enable(enable), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cfg_load(cfg_load), .cfg_base(cfg_base), .cfg_len(cfg_len),
    .cfg_step(cfg_step), .reads_en(reads_en), .ob_we(ob_we_a), .ob_data(ob_data_a),
    .writes_en(writes_en), .ib_re(ib_re_a), .ib_data(ib_data), .ib_valid(ib_valid),
    .wr_count(wr_count_a)
  );

  dma_stream_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .NUM_WR(NW),
                         .PERIOD(P1), .BEAT_PHASE(BP1)) u_dut_b (
    .clk(clk), .rst(rst), .enable(enable), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cfg_load(cfg_load), .cfg_base(cfg_base), .cfg_len(cfg_len),
    .cfg_step(cfg_step), .reads_en(reads_en), .ob_we(ob_we_b), .ob_data(ob_data_b),
    .writes_en(writes_en), .ib_re(ib_re_b), .ib_data(ib_data), .ib_valid(ib_valid),
    .wr_count(wr_count_b)
  );

  int n_total = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference model per instance: a port is described by how many running cycles
  // it has seen (tick) and how many beats it has served (beat); the address of
  // beat b is base + (b / L) * step + (b % L) modulo DEPTH.
  int           tick  [2][NP];
  int           beat  [2][NP];
  int           base  [2][NP];
  int           wlen  [2][NP];
  int           wstep [2][NP];
  int           wcnt  [2][NW];
  logic [DW-1:0] mem_m [2][DEPTH];
  logic [NR-1:0] e_we  [2];
  logic [DW-1:0] e_dat [2][NR];
  logic [NW-1:0] e_re  [2];

  function automatic int addr_of(int n, int k);
    int l;
    l = (wlen[n][k] == 0) ? DEPTH : wlen[n][k];
    return (base[n][k] + (beat[n][k] / l) * wstep[n][k] + beat[n][k] % l) % DEPTH;
  endfunction

  task automatic model_step(input int n);
    int p, bp;
    logic [NP-1:0] rq;
    logic [NW-1:0] nre;
    bit            wv [NW];
    int            wa [NW];
    logic [DW-1:0] wd [NW];
    p  = (n == 0) ? P0 : P1;
    bp = (n == 0) ? BP0 : BP1;
    rq = {writes_en, reads_en};
    if (rst) begin
      for (int k = 0; k < NP; k++) begin
        tick[n][k] = 0; beat[n][k] = 0; base[n][k] = 0; wlen[n][k] = 0; wstep[n][k] = 0;
      end
      for (int j = 0; j < NW; j++) wcnt[n][j] = 0;
      e_we[n] = '0;
      e_re[n] = '0;
      for (int i = 0; i < NR; i++) e_dat[n][i] = '0;
      if (mem_we) mem_m[n][mem_addr] = mem_wdata;
      return;
    end
    nre = '0;
    for (int i = 0; i < NR; i++) begin
      bit go;
      go = enable && reads_en[i] && ((tick[n][i] % p) == bp) && !cfg_load[i];
      e_we[n][i] = go;
      if (go) begin
        e_dat[n][i] = mem_m[n][addr_of(n, i)];
        beat[n][i]++;
      end
    end
    for (int j = 0; j < NW; j++) begin
      int k;
      k = NR + j;
      wv[j] = e_re[n][j] && ib_valid[j] && !cfg_load[k];
      wa[j] = 0;
      wd[j] = ib_data[j*DW +: DW];
      if (wv[j]) begin
        wa[j] = addr_of(n, k);
        beat[n][k]++;
        if (wcnt[n][j] < 65535) wcnt[n][j]++;
      end
      nre[j] = enable && writes_en[j] && ((tick[n][k] % p) == bp) && !cfg_load[k];
    end
    for (int k = 0; k < NP; k++) begin
      if (cfg_load[k]) begin
        base[n][k] = int'(cfg_base); wlen[n][k] = int'(cfg_len); wstep[n][k] = int'(cfg_step);
        beat[n][k] = 0; tick[n][k] = 0;
        if (k >= NR) wcnt[n][k-NR] = 0;
      end else if (enable && rq[k]) begin
        tick[n][k]++;
      end
    end
    if (mem_we) mem_m[n][mem_addr] = mem_wdata;
    for (int j = 0; j < NW; j++) if (wv[j]) mem_m[n][wa[j]] = wd[j];
    e_re[n] = nre;
  endtask

  task automatic check_outputs();
    logic [NR*DW-1:0] ed;
    logic [NW*16-1:0] ec;
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < NR; i++) ed[i*DW +: DW] = e_dat[n][i];
      for (int j = 0; j < NW; j++) ec[j*16 +: 16] = 16'(wcnt[n][j]);
      if (n == 0) begin
        chk("a_ob_we", 64'(ob_we_a), 64'(e_we[0]));
        chk("a_ob_data", 64'(ob_data_a), 64'(ed));
        chk("a_ib_re", 64'(ib_re_a), 64'(e_re[0]));
        chk("a_wr_count", 64'(wr_count_a), 64'(ec));
      end else begin
        chk("b_ob_we", 64'(ob_we_b), 64'(e_we[1]));
        chk("b_ob_data", 64'(ob_data_b), 64'(ed));
        chk("b_ib_re", 64'(ib_re_b), 64'(e_re[1]));
        chk("b_wr_count", 64'(wr_count_b), 64'(ec));
      end
    end
  endtask

  // One clock: inputs are already driven (at the falling edge); model, edge, check.
  task automatic cycle();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; enable = 1'b1; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    cfg_load = '0; reads_en = '0; writes_en = '0; ib_valid = '0; ib_data = '0;
  endtask

  task automatic load(input int k, input int b, input int l, input int s);
    idle();
    cfg_load[k] = 1'b1;
    cfg_base = AW'(b); cfg_len = AW'(l); cfg_step = AW'(s);
    cycle();
    cfg_load = '0;
  endtask

  logic [DW-1:0] q [$];
  int            qc [$];
  int            idx, bad, first_a, first_b;
  logic [DW-1:0] dat_a, dat_b;

  initial begin
    idle();
    cfg_base = '0; cfg_len = '0; cfg_step = '0;
    rst = 1'b1;
    @(negedge clk);
    cycle();
    cycle();
    chk("rst_wr_count", 64'(wr_count_a), 64'd0);
    chk("rst_ob_we", 64'({ob_we_a, ob_we_b}), 64'd0);
    rst = 1'b0;

    // Backdoor fill: mem[a] = a.
    for (int a = 0; a < DEPTH; a++) begin
      idle(); mem_we = 1'b1; mem_addr = AW'(a); mem_wdata = DW'(a);
      cycle();
    end

    // Sliding window on read port 0.
    load(0, 0, 46, 1);
    q.delete(); qc.delete();
    for (int c = 0; c < 420; c++) begin
      reads_en = 4'b0001;
      cycle();
      if (ob_we_a[0]) begin q.push_back(ob_data_a[DW-1:0]); qc.push_back(c); end
    end
    chk("slide_beats", 64'(q.size()), 64'd140);
    if (q.size() == 140) begin
      foreach (q[b]) if (b inside {0, 45, 46, 91, 92, 139})
        chk("slide_data", 64'(q[b]), 64'(b / 46 + b % 46));
      bad = 0;
      for (int b = 1; b < 140; b++) if (qc[b] - qc[b-1] != 3) bad++;
      chk("slide_gap", 64'(bad), 64'd0);
    end

    // Circular replay on read port 1.
    load(1, 100, 27, 0);
    q.delete();
    for (int c = 0; c < 180; c++) begin
      reads_en = 4'b0010;
      cycle();
      if (ob_we_a[1]) q.push_back(ob_data_a[DW +: DW]);
    end
    chk("circ_beats", 64'(q.size()), 64'd60);
    idx = -1;
    for (int b = 1; b < q.size(); b++) if (idx < 0 && q[b] == 16'd100) idx = b;
    chk("circ_period", 64'(idx), 64'd27);
    if (q.size() >= 55) begin
      chk("circ_first", 64'(q[0]), 64'd100);
      chk("circ_last", 64'(q[26]), 64'd126);
      chk("circ_again", 64'(q[54]), 64'd100);
    end

    // Write capture on write port 0, then read the words back through read port 2.
    load(NR, 200, 0, 0);
    for (int c = 0; c < 60 && wcnt[0][0] < 5; c++) begin
      writes_en = 2'b01; ib_valid = 2'b11;
      ib_data = {16'h0000, 16'h3C00 + 16'(wcnt[0][0])};
      cycle();
    end
    idle();
    cycle();
    chk("wr_count5", 64'(wr_count_a[15:0]), 64'd5);
    load(2, 200, 5, 0);
    q.delete();
    for (int c = 0; c < 15; c++) begin
      reads_en = 4'b0100;
      cycle();
      if (ob_we_a[2]) q.push_back(ob_data_a[2*DW +: DW]);
    end
    chk("wr_back_n", 64'(q.size()), 64'd5);
    foreach (q[b]) chk("wr_back", 64'(q[b]), 64'(16'h3C00 + b));

    // PERIOD 1 instance: 10 beats, 3-cycle enable gap, 10 more beats.
    load(3, 10, 0, 0);
    q.delete();
    bad = 0;
    for (int c = 0; c < 23; c++) begin
      reads_en = 4'b1000;
      enable = !(c >= 10 && c < 13);
      cycle();
      if (ob_we_b[3] != (c < 10 || c >= 13)) bad++;
      if (ob_we_b[3]) q.push_back(ob_data_b[3*DW +: DW]);
    end
    chk("p1_pattern", 64'(bad), 64'd0);
    chk("p1_beats", 64'(q.size()), 64'd20);
    foreach (q[b]) if (b == 9 || b == 10 || b == 19) chk("p1_data", 64'(q[b]), 64'(10 + b));

    // cfg_load coinciding with a launch.
    load(0, 50, 0, 0);
    reads_en = 4'b0001;
    cycle();
    cfg_load[0] = 1'b1; cfg_base = AW'(70); cfg_len = '0; cfg_step = '0;
    cycle();
    chk("ld_drop_a", 64'(ob_we_a[0]), 64'd0);
    chk("ld_drop_b", 64'(ob_we_b[0]), 64'd0);
    cfg_load = '0;
    first_a = -1; first_b = -1; dat_a = '0; dat_b = '0;
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (ob_we_a[0] && first_a < 0) begin first_a = c; dat_a = ob_data_a[DW-1:0]; end
      if (ob_we_b[0] && first_b < 0) begin first_b = c; dat_b = ob_data_b[DW-1:0]; end
    end
    chk("ld_next_a", 64'(dat_a), 64'd70);
    chk("ld_next_b", 64'(dat_b), 64'd70);
    chk("ld_when_b", 64'(first_b), 64'd0);

    // Reset in the middle of traffic, then run without reloading.
    idle();
    for (int c = 0; c < 7; c++) begin
      reads_en = 4'b1111; writes_en = 2'b11;
      cycle();
    end
    rst = 1'b1;
    cycle();
    chk("mid_rst_strobes", 64'({ob_we_a, ob_we_b, ib_re_a, ib_re_b}), 64'd0);
    chk("mid_rst_count", 64'(wr_count_a), 64'd0);
    idle();
    first_a = -1; first_b = -1; dat_a = '1; dat_b = '1;
    for (int c = 0; c < 8; c++) begin
      reads_en = 4'b0001;
      cycle();
      if (ob_we_a[0] && first_a < 0) begin first_a = c; dat_a = ob_data_a[DW-1:0]; end
      if (ob_we_b[0] && first_b < 0) begin first_b = c; dat_b = ob_data_b[DW-1:0]; end
    end
    chk("post_rst_when_a", 64'(first_a), 64'(BP0));
    chk("post_rst_when_b", 64'(first_b), 64'(BP1));
    chk("post_rst_data_a", 64'(dat_a), 64'd0);
    chk("post_rst_data_b", 64'(dat_b), 64'd0);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      enable = ($urandom_range(0, 4) != 0);
      mem_we = ($urandom_range(0, 7) == 0);
      mem_addr = AW'($urandom);
      mem_wdata = DW'($urandom);
      for (int k = 0; k < NP; k++) cfg_load[k] = ($urandom_range(0, 19) == 0);
      cfg_base = AW'($urandom);
      cfg_len = ($urandom_range(0, 9) == 0) ? '0 : AW'($urandom_range(1, 40));
      cfg_step = AW'($urandom_range(0, 3) == 0 ? 0 : $urandom);
      reads_en = NR'($urandom);
      writes_en = NW'($urandom);
      ib_valid = NW'($urandom);
      ib_data = ($urandom_range(0, 1) == 0) ? 32'($urandom) : {16'h0000, 16'($urandom)};
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
